ysyx_040729_ifu: RTL and testbench

- Instruction fetch unit sitting directly upstream of the decode stage.
- Holds the architectural PC and issues one fetch request at a time on a valid/ready instruction-memory port.
- Presents the fetched instruction and its PC to decode through a valid/ready handoff.
- Advances to the next-PC value computed by decode when that handoff completes; only one instruction is ever in flight.

---
 rtl/ysyx_040729_ifu.sv | 137 +++++++++++++
 tb/tb_ysyx_040729_ifu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040729_ifu.sv
// Instruction fetch unit: one fetch in flight, valid/ready to imem and to decode.
// Optional IFU_PERF_CNT_EN adds handoff and stall performance counters.
module ysyx_040729_ifu #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter int                    BUS_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_resp_valid_i,
    input  logic [BUS_WIDTH-1:0]  imem_resp_data_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    input  logic                  stall_i,
    input  logic [ADDR_WIDTH-1:0] pc_next_i,
    output logic [INST_WIDTH-1:0] instruction_o,
    output logic [ADDR_WIDTH-1:0] pc_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetch_cnt_o,
    output logic [63:0]           perf_stall_cnt_o
`endif
);

    localparam logic [INST_WIDTH-1:0] NOP = 32'h0000_0013;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // while valid is 1 and ready is 0, the presented payload does not change.
    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic                    valid_q, valid_d;
    logic                    handoff;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        handoff  = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    // pc[2] picks which of the two packed instructions in the beat is ours
                    inst_d   = pc_q[2] ? imem_resp_data_i[2*INST_WIDTH-1:INST_WIDTH]
                                       : imem_resp_data_i[INST_WIDTH-1:0];
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready_i && !stall_i) begin
                    handoff = 1'b1;
                    pc_d    = pc_next_i;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            inst_q   <= NOP;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_addr_o      = {pc_q[ADDR_WIDTH-1:3], 3'b000};
    assign inst_valid_o     = valid_q;
    assign instruction_o    = inst_q;
    assign pc_o             = pc_out_q;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (handoff) begin
            fetch_cnt_d = fetch_cnt_q + 64'd1;
        end
        if (state_q == S_HOLD && stall_i) begin
            stall_cnt_d = stall_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 64'd0;
            stall_cnt_q <= 64'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_ysyx_040729_ifu.sv
// Directed bench for ysyx_040729_ifu: cycle-stepped stimulus with hand-computed expectations.
module tb_ysyx_040729_ifu;

    logic        clock;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_resp_valid_i;
    logic [63:0] imem_resp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        stall_i;
    logic [63:0] pc_next_i;
    logic [31:0] instruction_o;
    logic [63:0] pc_o;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_o;
    logic [63:0] perf_stall_cnt_o;
`endif

    int tests_run;
    int tests_failed;

    ysyx_040729_ifu dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_addr_o       (imem_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .stall_i           (stall_i),
        .pc_next_i         (pc_next_i),
        .instruction_o     (instruction_o),
        .pc_o              (pc_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o  (perf_fetch_cnt_o),
        .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = 64'h0;
        inst_ready_i      = 1'b0;
        stall_i           = 1'b0;
        pc_next_i         = 64'h0;

        tick();
        tick();
        check("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        check("rst_instruction", {32'd0, instruction_o}, 64'h13);
        check("rst_pc_o", pc_o, 64'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        check("rst_fetch_cnt", perf_fetch_cnt_o, 64'd0);
        check("rst_stall_cnt", perf_stall_cnt_o, 64'd0);
`endif

        // First fetch: BOOT, REQ accept, response one cycle after accept.
        reset = 1'b1;
        tick();
        check("boot_exit_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        check("first_addr", imem_addr_o, 64'h8000_0000);
        check("boot_exit_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        imem_req_ready_i = 1'b1;
        tick();
        check("wait_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        check("wait_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 64'h00A0_0093_0010_0113;
        tick();
        imem_resp_valid_i = 1'b0;
        check("first_inst_valid", {63'd0, inst_valid_o}, 64'd1);
        check("first_instruction", {32'd0, instruction_o}, 64'h0010_0113);
        check("first_pc_o", pc_o, 64'h8000_0000);
        check("hold_req_valid", {63'd0, imem_req_valid_o}, 64'd0);

        // Handoff to 0x8000_0004: same aligned address, upper word selected.
        inst_ready_i = 1'b1;
        pc_next_i    = 64'h8000_0004;
        tick();
        inst_ready_i = 1'b0;
        pc_next_i    = 64'h0;
        check("handoff_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        check("second_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        check("second_addr", imem_addr_o, 64'h8000_0000);
        tick();
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 64'h00A0_0093_0010_0113;
        tick();
        imem_resp_valid_i = 1'b0;
        check("second_instruction", {32'd0, instruction_o}, 64'h00A0_0093);
        check("second_pc_o", pc_o, 64'h8000_0004);

        // Handoff to 0x8000_0008 then memory not ready for 5 cycles, with a spurious response.
        inst_ready_i     = 1'b1;
        pc_next_i        = 64'h8000_0008;
        imem_req_ready_i = 1'b0;
        tick();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid_i = (i == 2);
            imem_resp_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
            check($sformatf("stall_mem_req_valid_%0d", i), {63'd0, imem_req_valid_o}, 64'd1);
            check($sformatf("stall_mem_addr_%0d", i), imem_addr_o, 64'h8000_0008);
            check($sformatf("req_spurious_instr_%0d", i), {32'd0, instruction_o}, 64'h00A0_0093);
            check($sformatf("req_inst_valid_%0d", i), {63'd0, inst_valid_o}, 64'd0);
        end
        imem_resp_valid_i = 1'b0;
        imem_req_ready_i  = 1'b1;
        tick();
        check("late_accept_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 64'h1111_2222_3333_4444;
        tick();
        imem_resp_valid_i = 1'b0;
        check("third_instruction", {32'd0, instruction_o}, 64'h3333_4444);
        check("third_pc_o", pc_o, 64'h8000_0008);

        // Decode stalls for 3 cycles with ready high and pc_next toggling.
        inst_ready_i = 1'b1;
        stall_i      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_next_i         = (i % 2 == 0) ? 64'h8000_0040 : 64'h8000_0080;
            imem_resp_valid_i = (i == 1);
            imem_resp_data_i  = 64'hAAAA_BBBB_CCCC_DDDD;
            tick();
            check($sformatf("stall_inst_valid_%0d", i), {63'd0, inst_valid_o}, 64'd1);
            check($sformatf("stall_req_valid_%0d", i), {63'd0, imem_req_valid_o}, 64'd0);
            check($sformatf("stall_instruction_%0d", i), {32'd0, instruction_o}, 64'h3333_4444);
            check($sformatf("stall_pc_o_%0d", i), pc_o, 64'h8000_0008);
        end
        imem_resp_valid_i = 1'b0;
`ifdef IFU_PERF_CNT_EN
        check("fetch_cnt_mid", perf_fetch_cnt_o, 64'd2);
        check("stall_cnt_mid", perf_stall_cnt_o, 64'd3);
`endif
        stall_i   = 1'b0;
        pc_next_i = 64'h8000_0100;
        tick();
        inst_ready_i = 1'b0;
        pc_next_i    = 64'h0;
        check("after_stall_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        check("after_stall_addr", imem_addr_o, 64'h8000_0100);
`ifdef IFU_PERF_CNT_EN
        check("fetch_cnt_pre_rst", perf_fetch_cnt_o, 64'd3);
`endif

        // Reset pulse while waiting for the response.
        tick();
        check("pre_rst_wait_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
        check("async_rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        check("async_rst_instruction", {32'd0, instruction_o}, 64'h13);
        check("async_rst_pc_o", pc_o, 64'h8000_0000);
        check("async_rst_addr", imem_addr_o, 64'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        check("async_rst_fetch_cnt", perf_fetch_cnt_o, 64'd0);
        check("async_rst_stall_cnt", perf_stall_cnt_o, 64'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        check("refetch_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        check("refetch_addr", imem_addr_o, 64'h8000_0000);

        // Self-loop: pc_next equal to pc refetches the same address.
        tick();
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 64'h0000_0000_DEAD_BEEF;
        tick();
        imem_resp_valid_i = 1'b0;
        check("loop_instruction", {32'd0, instruction_o}, 64'hDEAD_BEEF);
        inst_ready_i = 1'b1;
        pc_next_i    = 64'h8000_0000;
        tick();
        inst_ready_i = 1'b0;
        check("loop_addr", imem_addr_o, 64'h8000_0000);
        check("loop_req_valid", {63'd0, imem_req_valid_o}, 64'd1);
        tick();
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = 64'h0000_0000_1234_5678;
        tick();
        imem_resp_valid_i = 1'b0;
        check("loop_instruction2", {32'd0, instruction_o}, 64'h1234_5678);
        check("loop_pc_o", pc_o, 64'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        check("loop_fetch_cnt", perf_fetch_cnt_o, 64'd1);
        check("loop_stall_cnt", perf_stall_cnt_o, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
